// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: datapath widths, reserved tag, ICC bit layout
// and the Common Data Bus message carried by every result path.
package tomasulo_pkg;

  localparam int TAG_W = 5;
  localparam int VAL_W = 32;
  localparam int ICC_W = 4;

  // All-ones tag marks "no producer"; also the idle value of the CDB tag.
  localparam logic [TAG_W-1:0] INVALID_TAG = 5'b11111;

  // ICC flags are ordered {c, v, z, n}.
  localparam int ICC_C = 3;
  localparam int ICC_V = 2;
  localparam int ICC_Z = 1;
  localparam int ICC_N = 0;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [VAL_W-1:0] val;
    logic [ICC_W-1:0] icc;
    logic             icc_valid;
  } cdb_msg_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves past the winner whenever advance is high.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win_idx;
  logic             found;

  // Modulo-N add; N need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_add(logic [PTR_W-1:0] base, int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return PTR_W'(s);
  endfunction

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    grant   = '0;
    found   = 1'b0;
    win_idx = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (!found && req[wrap_add(ptr_q, i)]) begin
        found   = 1'b1;
        win_idx = wrap_add(ptr_q, i);
      end
    end
    if (found) grant[win_idx] = 1'b1;

    ptr_d = ptr_q;
    if (advance && found) ptr_d = wrap_add(win_idx, 1);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one-entry holding register per reservation station,
// round-robin selection, and a registered single-cycle CDB broadcast.
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       in_req_valid,
  output logic [NUM_SRC-1:0]       out_req_ready,
  input  logic [NUM_SRC*TAG_W-1:0] in_req_tag,
  input  logic [NUM_SRC*VAL_W-1:0] in_req_val,
  input  logic [NUM_SRC*ICC_W-1:0] in_req_icc,
  input  logic [NUM_SRC-1:0]       in_req_icc_valid,
  output logic                     out_CDB_broadcast,
  output logic [TAG_W-1:0]         out_CDB_tag,
  output logic [VAL_W-1:0]         out_CDB_val,
  output logic [ICC_W-1:0]         out_CDB_icc,
  output logic                     out_CDB_icc_valid,
  output logic                     out_bad_tag
);

  logic [NUM_SRC-1:0] hold_full_q, hold_full_d;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] accept;
  logic [NUM_SRC-1:0] store;
  cdb_msg_t           hold_q [NUM_SRC];
  cdb_msg_t           cdb_q;
  cdb_msg_t           cdb_sel;
  logic               cdb_bcast_q;
  logic               bad_tag_q;

  // Only results already sitting in a holding register compete; a grant is
  // always consumed, so the pointer advances on every grant.
  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (hold_full_q),
    .advance (1'b1),
    .grant   (grant)
  );

  // Ready includes the grant so a register drained this cycle can refill at
  // the same edge, sustaining one result per cycle per source.
  assign out_req_ready = rst ? '0 : (~hold_full_q | grant);

  always_comb begin
    cdb_sel     = '0;
    hold_full_d = hold_full_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      accept[k] = in_req_valid[k] & out_req_ready[k];
      store[k]  = accept[k] && (in_req_tag[k*TAG_W +: TAG_W] != INVALID_TAG);
      if (grant[k]) cdb_sel = hold_q[k];
      if (store[k])      hold_full_d[k] = 1'b1;
      else if (grant[k]) hold_full_d[k] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full_q <= '0;
      cdb_bcast_q <= 1'b0;
      cdb_q       <= '{tag: INVALID_TAG, val: '0, icc: '0, icc_valid: 1'b0};
      bad_tag_q   <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      cdb_bcast_q <= |grant;
      if (|grant) cdb_q           <= cdb_sel;
      else        cdb_q.icc_valid <= 1'b0;
      if (|(accept & ~store)) bad_tag_q <= 1'b1;
    end
  end

  // NOTE: payload storage has no reset; hold_full_q alone says whether an
  // entry is meaningful, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_SRC; k++) begin
      if (store[k]) begin
        hold_q[k] <= '{tag:       in_req_tag[k*TAG_W +: TAG_W],
                       val:       in_req_val[k*VAL_W +: VAL_W],
                       icc:       in_req_icc[k*ICC_W +: ICC_W],
                       icc_valid: in_req_icc_valid[k]};
      end
    end
  end

  assign out_CDB_broadcast = cdb_bcast_q;
  assign out_CDB_tag       = cdb_q.tag;
  assign out_CDB_val       = cdb_q.val;
  assign out_CDB_icc       = cdb_q.icc;
  assign out_CDB_icc_valid = cdb_q.icc_valid;
  assign out_bad_tag       = bad_tag_q;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Common Data Bus arbiter and driver placed directly downstream of the functional-unit reservation stations (add, logic/shift, load).
- Each station offers a completed result (tag, value, ICC flags) through a valid/ready handshake into a one-entry holding register.
- The block grants one holding register per cycle by round-robin and drives a registered, single-cycle CDB broadcast.
- The broadcast is consumed by all reservation stations, the register status table and the ICC rename logic.

Parameters:
NUM_SRC, 4, number of requesting stations (legal range 2..8)
TAG_W, 5, reservation-station tag width
VAL_W, 32, result value width
ICC_W, 4, ICC flag width, ordered {c, v, z, n}

Ports:
clk  in  1  single clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
in_req_valid  in  NUM_SRC  per-source result valid
out_req_ready  out  NUM_SRC  per-source holding register can accept this cycle
in_req_tag  in  NUM_SRC*TAG_W  per-source result tag, source k at [k*TAG_W +: TAG_W]
in_req_val  in  NUM_SRC*VAL_W  per-source result value
in_req_icc  in  NUM_SRC*ICC_W  per-source ICC flags
in_req_icc_valid  in  NUM_SRC  per-source "result updates ICC" (the _CC opcodes)
out_CDB_broadcast  out  1  one-cycle broadcast strobe
out_CDB_tag  out  TAG_W  broadcast tag
out_CDB_val  out  VAL_W  broadcast value
out_CDB_icc  out  ICC_W  broadcast ICC flags
out_CDB_icc_valid  out  1  broadcast carries an ICC update
out_bad_tag  out  1  sticky; set when an INVALID_TAG result was offered

Behaviour:
Reset:
- When rst=1 at an edge, all holding registers are emptied and the round-robin pointer is set to 0.
- out_CDB_broadcast=0, out_CDB_icc_valid=0, out_CDB_tag=INVALID_TAG, out_CDB_val=0, out_CDB_icc=0, out_bad_tag=0.
- rst mid-operation discards every held and in-flight result; no broadcast occurs in the cycle after the reset edge.
- out_req_ready is 0 while rst=1.

Holding registers (one per source):
- hold_full[k], hold_tag/val/icc/icc_valid[k].
- Handshake completes at an edge when in_req_valid[k] & out_req_ready[k]; the payload is captured at that edge.
- out_req_ready[k] = !hold_full[k] | grant[k]. This is combinational, so same-cycle drain and refill of source k are allowed, giving one result per cycle per source when continuously granted.
- A source holds valid and payload stable until ready; the block does not check this.
- Offered tag == INVALID_TAG (all ones): accepted but not stored, and out_bad_tag is set (sticky until rst).

Arbitration:
- Requests = hold_full; contents of this cycle's handshakes are not eligible until the next edge.
- Round-robin: search starts at pointer p, ascending mod NUM_SRC; the first full register wins (grant one-hot).
- After a grant to k, p <= (k+1) mod NUM_SRC. With no request, p is unchanged.

Broadcast:
- At the edge where grant[k]=1, the CDB outputs load hold_*[k], out_CDB_broadcast <= 1, and hold_full[k] clears unless refilled at the same edge.
- With no grant, out_CDB_broadcast <= 0 and out_CDB_icc_valid <= 0; tag, val and icc hold their last values.
- The strobe is exactly one cycle per result. Back-to-back grants give a continuous strobe with a new tag each cycle.
- Latency: accepted at edge E, earliest broadcast visible after edge E+1.
- The strobe is level-high only for one cycle; consumers sample on clk, never on strobe edges.

No state machine beyond per-source full flags and pointer. Width rules: value and ICC are passed unmodified with no arithmetic.

Decomposition:
Shared package tomasulo_pkg holds:
- TAG_W, VAL_W, ICC_W, INVALID_TAG (5'b11111)
- ICC bit index constants: ICC_C=3, ICC_V=2, ICC_Z=1, ICC_N=0
- A cdb_msg struct {tag, val, icc, icc_valid}

One sub-module, rr_arbiter (parameter N): inputs req[N], advance; outputs grant[N] one-hot. It owns the pointer and is reusable by the issue stage.

Test Plan:
1. rst held 2 cycles, then source 0 offers tag 3, val 0x0000_0010 at edge E → out_CDB_broadcast=1 with tag 3, val 0x10 after E+1 only, then 0.
2. All 4 sources offer at the same edge (tags 1,2,3,4) after reset → broadcasts on four consecutive cycles in order 1,2,3,4; p returns to 0.
3. Source 2 held valid continuously with tags 5,6,7, others idle → ready stays 1, strobe continuous for 3 cycles carrying 5,6,7.
4. Sources 1 and 3 both full with p=2 → tag of source 3 broadcast first, then source 1.
5. Source 0 offers tag 5'b11111 → no broadcast; out_bad_tag=1 and stays set until rst.
6. rst asserted while sources 0 and 1 are full → next cycle strobe 0, all ready=1 after rst drops, nothing from before the reset is ever broadcast; an icc_valid=1 result (icc 4'b0010) reproduces out_CDB_icc=4'b0010 with out_CDB_icc_valid=1.
